// File: rtl/fullrate.sv
// Re-interleaves split-order frames (evens then odds) back to natural order
// through a two-bank ping-pong buffer, emitting each frame as a gap-free burst.
`timescale 1ns/1ps
module fullrate #(
  parameter int unsigned DBW = 3,
  parameter int unsigned CBW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DBW-1:0] din,
  input  logic           din_valid,
  output logic [DBW-1:0] dout,
  output logic           dout_valid,
  output logic [CBW-1:0] dout_cnt
);

  localparam int unsigned N = 2 ** CBW;
  localparam logic [CBW-1:0] LAST = CBW'(N - 1);

  typedef enum logic {IDLE, READ} state_t;

  logic [DBW-1:0] mem [2][N];
  logic [CBW-1:0] wr_cnt;
  logic [CBW-1:0] rd_cnt;
  logic [CBW-1:0] rd_addr;
  logic           wr_bank;
  logic           rd_bank;
  logic [1:0]     full;
  logic [1:0]     full_nxt;
  logic           rd_go;
  logic           wr_last;
  logic           rd_last;
  state_t         state;

  // Position j of the output frame lives at split-order address {j[0], j[CBW-1:1]}.
  assign rd_addr = {rd_cnt[0], rd_cnt[CBW-1:1]};
  // A full bank is read starting the same edge IDLE first sees its flag.
  assign rd_go   = (state == READ) || full[rd_bank];
  assign wr_last = din_valid && (wr_cnt == LAST);
  assign rd_last = rd_go && (rd_cnt == LAST);

  // Reader clears and writer sets always target different banks, so both apply.
  always_comb begin
    full_nxt = full;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && din_valid) mem[wr_bank][wr_cnt] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      rd_cnt     <= '0;
      rd_bank    <= 1'b0;
      full       <= 2'b00;
      state      <= IDLE;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_cnt   <= '0;
    end else begin
      full <= full_nxt;
      if (din_valid) begin
        wr_cnt <= wr_cnt + CBW'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (rd_go) begin
        dout       <= mem[rd_bank][rd_addr];
        dout_valid <= 1'b1;
        dout_cnt   <= rd_cnt;
        if (rd_last) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
          state   <= full[~rd_bank] ? READ : IDLE;
        end else begin
          rd_cnt <= rd_cnt + CBW'(1);
          state  <= READ;
        end
      end else begin
        dout_valid <= 1'b0;
        state      <= IDLE;
      end
    end
  end

  // There is no backpressure; a write into an undrained bank would corrupt it.
  always_ff @(posedge clk) begin
    if (rst_n && din_valid) assert (!full[wr_bank]) else $error("fullrate: write to full bank %0d", wr_bank);
  end

endmodule

// File: tb/tb_fullrate.sv
// Directed and randomised checks of fullrate frame re-interleaving with N = 8.
`timescale 1ns/1ps
module tb_fullrate;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] dout_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_last;
  logic [7:0] oq[$];
  int cq[$];
  int tq[$];
  logic [7:0] iq[$];
  int perm[8] = '{0, 4, 1, 5, 2, 6, 3, 7};

  fullrate #(.DBW(8), .CBW(3)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_cnt(dout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, observe 1ns later and log any valid output.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dout_valid) begin
      oq.push_back(dout);
      cq.push_back(int'(dout_cnt));
      tq.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] d);
    din = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic clear_q();
    oq.delete(); cq.delete(); tq.delete(); iq.delete();
  endtask

  // Check one burst of 8 outputs at queue offset k0 from base value b, starting at edge t0.
  task automatic chk_frame(input string tag, input int k0, input int b, input int t0);
    for (int j = 0; j < 8; j++) begin
      chk({tag, "_data"}, oq[k0+j], 32'(b + perm[j]));
      chk({tag, "_cnt"}, cq[k0+j], 32'(j));
      chk({tag, "_time"}, tq[k0+j], 32'(t0 + j));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din = 8'd5;
    din_valid = 1'b1;

    // 1: reset with din_valid high
    idle(2);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_cnt", dout_cnt, 0);
    rst_n = 1'b1;
    din_valid = 1'b0;
    clear_q();
    idle(12);
    chk("rst_no_out", oq.size(), 0);

    // 2: one continuous frame
    clear_q();
    for (int i = 0; i < 8; i++) send(8'(i));
    t_last = cyc;
    idle(12);
    chk("f1_size", oq.size(), 8);
    if (oq.size() == 8) chk_frame("f1", 0, 0, t_last + 1);
    chk("f1_hold_valid", dout_valid, 0);
    chk("f1_hold_dout", dout, 7);
    chk("f1_hold_cnt", dout_cnt, 7);

    // 3: two back-to-back frames
    clear_q();
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      if (i == 7) t_last = cyc;
    end
    idle(20);
    chk("b2b_size", oq.size(), 16);
    if (oq.size() == 16) begin
      chk_frame("b2b0", 0, 0, t_last + 1);
      chk_frame("b2b1", 8, 8, t_last + 9);
    end

    // 4: gapped input
    clear_q();
    for (int i = 0; i < 7; i++) begin
      send(8'(i));
      idle(1);
    end
    chk("gap_early", oq.size(), 0);
    send(8'd7);
    t_last = cyc;
    idle(12);
    chk("gap_size", oq.size(), 8);
    if (oq.size() == 8) chk_frame("gap", 0, 0, t_last + 1);

    // 5: reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) send(8'(i));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_q();
    for (int i = 20; i < 28; i++) send(8'(i));
    t_last = cyc;
    idle(12);
    chk("mid_rst_size", oq.size(), 8);
    if (oq.size() == 8) chk_frame("mid_rst", 0, 20, t_last + 1);

    // 6: random data and gaps, 50 frames
    clear_q();
    for (int f = 0; f < 50; f++) begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        iq.push_back(v);
        send(v);
        idle($urandom_range(0, 2));
      end
    end
    idle(20);
    chk("rnd_size", oq.size(), 400);
    if (oq.size() == 400) begin
      for (int k = 0; k < 400; k++) begin
        int j;
        int src;
        j = k % 8;
        src = (k - j) + (j % 2) * 4 + j / 2;
        chk("rnd_data", oq[k], 32'(iq[src]));
        chk("rnd_cnt", cq[k], 32'(j));
        if (j != 0) chk("rnd_burst", tq[k], 32'(tq[k-1] + 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
